// File: rtl/bram_port_a_arbiter.sv
// Port-A arbiter for the shared block RAM: CPU has fixed priority, the aux master
// is guaranteed a slot by a starvation counter, and read data is steered to its owner.
module bram_port_a_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_a,
  input  logic [DATA_WIDTH-1:0] q_a,
  output logic [3:0]            starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t     rd_owner;
  logic [3:0] starve_q;
  logic       aux_due;

  always_comb begin
    aux_due = (starve_q >= LIMIT);
    // Grants are suppressed while reset is held so nothing reaches the RAM.
    cpu_gnt = !reset && cpu_req && !(aux_req && aux_due);
    aux_gnt = !reset && aux_req && (!cpu_req || aux_due);
    addr_a  = '0;
    data_a  = '0;
    we_a    = 1'b0;
    if (cpu_gnt) begin
      addr_a = cpu_addr;
      data_a = cpu_wdata;
      we_a   = cpu_we;
    end else if (aux_gnt) begin
      addr_a = aux_addr;
      data_a = aux_wdata;
      we_a   = aux_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= 4'd0;
      rd_owner <= OWN_NONE;
    end else begin
      if (aux_req && !aux_gnt) begin
        if (starve_q != 4'hF) starve_q <= starve_q + 4'd1;
      end else begin
        starve_q <= 4'd0;
      end

      if (cpu_gnt && !cpu_we)      rd_owner <= OWN_CPU;
      else if (aux_gnt && !aux_we) rd_owner <= OWN_AUX;
      else                         rd_owner <= OWN_NONE;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign aux_rvalid = (rd_owner == OWN_AUX);
  assign cpu_rdata  = q_a;
  assign aux_rdata  = q_a;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_bram_port_a_arbiter.sv
// Bench for bram_port_a_arbiter: directed scenarios plus randomized traffic checked
// against a shadow memory, arbitration rules and a read-return scoreboard.
module tb_bram_port_a_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0;
  logic [AW-1:0] cpu_addr = '0, aux_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, aux_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, we_a;
  logic [DW-1:0] cpu_rdata, aux_rdata, data_a, q_a;
  logic [AW-1:0] addr_a;
  logic [3:0]    starve_cnt;

  bram_port_a_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a), .starve_cnt(starve_cnt)
  );

  always #5 clock = ~clock;

  // Behavioural BRAM with registered read output.
  logic [DW-1:0] mem [256];
  always @(posedge clock) begin
    if (we_a) mem[addr_a[7:0]] <= data_a;
    q_a <= mem[addr_a[7:0]];
  end

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] aux_q[$];
  int  checks = 0;
  int  failures = 0;
  int  m_starve = 0;
  bit  g_cpu, g_aux;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                      input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad);
    logic [15:0] e_addr, e_data;
    logic        e_we;
    @(negedge clock);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
    #1;
    g_cpu = 0; g_aux = 0;
    if (cr && ar) begin
      if (m_starve < SL) g_cpu = 1; else g_aux = 1;
    end else begin
      g_cpu = cr;
      g_aux = ar;
    end
    e_addr = g_cpu ? ca : (g_aux ? aa : 16'h0);
    e_data = g_cpu ? cd : (g_aux ? ad : 16'h0);
    e_we   = g_cpu ? cw : (g_aux ? aw : 1'b0);
    chk("cpu_gnt", cpu_gnt, g_cpu);
    chk("aux_gnt", aux_gnt, g_aux);
    chk("addr_a", addr_a, e_addr);
    chk("data_a", data_a, e_data);
    chk("we_a", we_a, e_we);
    chk("starve_cnt", starve_cnt, m_starve);
    if (g_cpu) begin
      if (cw) ref_mem[ca[7:0]] = cd; else cpu_q.push_back(ref_mem[ca[7:0]]);
    end
    if (g_aux) begin
      if (aw) ref_mem[aa[7:0]] = ad; else aux_q.push_back(ref_mem[aa[7:0]]);
    end
    m_starve = (ar && !g_aux) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  // Read-return monitor: every read granted last cycle must come back now, in order.
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_rvalid || cpu_q.size() != 0) begin
        chk("cpu_rvalid", cpu_rvalid, cpu_q.size() != 0);
        if (cpu_q.size() != 0) begin
          logic [DW-1:0] e;
          e = cpu_q.pop_front();
          if (cpu_rvalid) chk("cpu_rdata", cpu_rdata, e);
        end
      end
      if (aux_rvalid || aux_q.size() != 0) begin
        chk("aux_rvalid", aux_rvalid, aux_q.size() != 0);
        if (aux_q.size() != 0) begin
          logic [DW-1:0] e;
          e = aux_q.pop_front();
          if (aux_rvalid) chk("aux_rdata", aux_rdata, e);
        end
      end
      if (cpu_rvalid && aux_rvalid) chk("rvalid_exclusive", 1, 0);
    end
  end

  initial begin
    int first_aux;
    bit c_pend, a_pend;
    logic cr, cw, ar, aw;
    logic [15:0] ca, cd, aa, ad;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;

    #1;
    chk("reset_starve", starve_cnt, 0);
    chk("reset_cpu_rvalid", cpu_rvalid, 0);
    chk("reset_aux_rvalid", aux_rvalid, 0);
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b0;

    // CPU read alone
    step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    idle();
    // simultaneous requests, aux served once the CPU drops
    step(1, 1, 16'h0020, 16'h1234, 1, 0, 16'h0030, 16'h0);
    step(0, 0, 16'h0000, 16'h0, 1, 0, 16'h0030, 16'h0);
    idle();
    // starvation with continuous CPU requests
    first_aux = -1;
    a_pend = 1;
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 16'(16'h0050 + i), 16'h0, a_pend, 0, 16'h0060, 16'h0);
      if (a_pend && aux_gnt) begin
        first_aux = i;
        a_pend = 0;
      end
    end
    chk("starve_wait", first_aux, SL);
    idle();
    // pipelined alternating reads
    step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0030, 16'h0);
    idle();
    // write then read of the same address
    step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'h00FF);
    step(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0);
    idle();

    // reset arrives while a CPU read is in flight
    step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0030, 16'h0);
    @(posedge clock); #2;
    reset = 1'b1;
    cpu_q.delete(); aux_q.delete();
    m_starve = 0;
    #1;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_starve", starve_cnt, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_aux_gnt", aux_gnt, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    idle();

    // randomized traffic obeying the hold-until-granted rule
    c_pend = 0; a_pend = 0;
    cr = 0; cw = 0; ca = 0; cd = 0; ar = 0; aw = 0; aa = 0; ad = 0;
    for (int n = 0; n < 400; n++) begin
      if (!c_pend) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1) == 1;
        ca = 16'($urandom_range(0, 63));
        cd = 16'($urandom);
      end
      if (!a_pend) begin
        ar = $urandom_range(0, 1) == 1;
        aw = $urandom_range(0, 1) == 1;
        aa = 16'($urandom_range(0, 63));
        ad = 16'($urandom);
      end
      step(cr, cw, ca, cd, ar, aw, aa, ad);
      c_pend = cr && !g_cpu;
      a_pend = ar && !g_aux;
    end
    idle();
    idle();
    @(negedge clock); #1;
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("aux_q_drained", aux_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_port_a_arbiter.md
# bram_port_a_arbiter

Shares the single read/write port A of the system block RAM between two masters: the CPU (instruction fetch and load/store, driven by the decoder FSM) and an auxiliary master (a memory-mapped input writer that deposits button/accelerometer state into RAM). The CPU has fixed priority. A starvation counter guarantees the auxiliary master a slot after a bounded wait. The block also routes the one-cycle-latent BRAM read data back to whichever master issued the read. It sits between the masters and `bram` port A; port B (VGA read) is untouched.

## Interface
- `DATA_WIDTH`, 16: RAM word width.
- `ADDR_WIDTH`, 16: RAM address width.
- `STARVE_LIMIT`, 4: number of consecutive denied aux-request cycles after which aux wins the next contested cycle. Legal range is 1..15.

- `clock` input, 1: single system clock. All state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high. Clears all state immediately.
- `cpu_req` input, 1: CPU requests an access this cycle.
- `cpu_we` input, 1: 1 = write, 0 = read.
- `cpu_addr` input, ADDR_WIDTH: CPU address.
- `cpu_wdata` input, DATA_WIDTH: CPU write data.
- `cpu_gnt` output, 1: CPU access is issued to the BRAM this cycle.
- `cpu_rvalid` output, 1: `cpu_rdata` holds the result of the CPU read granted in the previous cycle.
- `cpu_rdata` output, DATA_WIDTH: read data.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_gnt`, `aux_rvalid`, `aux_rdata`: same meaning as the CPU ports, for the aux master.
- `addr_a` output, ADDR_WIDTH: BRAM port A address.
- `data_a` output, DATA_WIDTH: BRAM port A write data.
- `we_a` output, 1: BRAM port A write enable.
- `q_a` input, DATA_WIDTH: BRAM port A registered read data.
- `starve_cnt` output, 4: current starvation count (debug).

## Operation
- At most one access per cycle. The grant is combinational from the requests and the registered state.
- Arbitration:
  - Only one request high: that master is granted.
  - Both requests high and `starve_cnt < STARVE_LIMIT`: CPU is granted.
  - Both requests high and `starve_cnt >= STARVE_LIMIT`: aux is granted.
  - Neither request high: no grant.
- BRAM side:
  - `addr_a`, `data_a` and `we_a` carry the granted master's `addr`/`wdata`/`we`.
  - With no grant: `addr_a`=0, `data_a`=0, `we_a`=0.
- Starvation counter:
  - Increments (saturating at 15) on each cycle where `aux_req`=1 and `aux_gnt`=0.
  - Clears to 0 on an aux grant.
  - Clears to 0 on a cycle with `aux_req`=0.
- Read return:
  - A registered 2-bit tag `rd_owner` ∈ {NONE, CPU, AUX} records the owner of a granted read (`we`=0).
  - `rd_owner` is NONE after a write or an idle cycle.
  - Next cycle: `cpu_rvalid` = (`rd_owner`==CPU), `aux_rvalid` = (`rd_owner`==AUX).
  - Both `rdata` outputs are wired to `q_a`; they are meaningful only while the matching `rvalid` is high.
- Requester rule: a master holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`=1 in the same cycle. It may drop or change `req` on the following cycle.
- Back-to-back grants to the same or alternating masters are legal every cycle.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the cycle `req` wins.
- Write latency is 0: the write is committed at the edge that ends the grant cycle.
- Read latency is 1 cycle: `rvalid` and `rdata` appear in the cycle after `gnt`.
- Pipelined reads are allowed. A grant in cycle N produces data in cycle N+1, while a new grant can issue in N+1.
- Reset values:
  - `starve_cnt`=0.
  - `rd_owner`=NONE, so `cpu_rvalid`=`aux_rvalid`=0.
  - During reset, `cpu_gnt`, `aux_gnt` and `we_a` are forced to 0.
- Reset asserted mid-read (grant in N, reset in N+1): `rvalid` drops to 0 immediately. The read result is discarded.
- Write then read of the same address in consecutive cycles returns the new data (BRAM read-after-write across cycles).
- Worst-case aux wait with continuous CPU requests is STARVE_LIMIT cycles. Aux is granted in the (STARVE_LIMIT+1)-th cycle of asserting `aux_req`.

## Test plan
- CPU read alone: `cpu_req`=1, `cpu_we`=0, addr 0x0010 holding 0xBEEF → `cpu_gnt`=1 that cycle. `addr_a`=0x0010 and `we_a`=0. Next cycle `cpu_rvalid`=1 with `cpu_rdata`=0xBEEF, and `aux_rvalid`=0.
- Simultaneous single requests: CPU write 0x1234→0x0020 and aux read of 0x0030 in the same cycle, `starve_cnt`=0 → `cpu_gnt`=1, `aux_gnt`=0, `we_a`=1, `starve_cnt`=1 next cycle. Aux is granted in the following cycle once `cpu_req` drops. `aux_rvalid` follows one cycle later.
- Starvation with STARVE_LIMIT=4: `cpu_req` held high continuously and `aux_req` raised at cycle 0 → aux denied in cycles 0–3 (`starve_cnt` 1..4). `aux_gnt`=1 and `cpu_gnt`=0 in cycle 4. `starve_cnt`=0 in cycle 5, where the CPU is granted again.
- Pipelined alternating reads: CPU read of A in cycle N, aux read of B in N+1 → `cpu_rvalid` in N+1 with data(A). `aux_rvalid` in N+2 with data(B). Never both `rvalid` signals high together.
- Write-then-read: aux writes 0x00FF to 0x0040, CPU reads 0x0040 in the next cycle → `cpu_rdata`=0x00FF.
- Reset mid-read: CPU read granted, then `reset` asserted asynchronously before the next edge → `cpu_rvalid`=0, `starve_cnt`=0 and `we_a`=0 during reset. The first grant after release behaves as in the first scenario.
